// File: rtl/data_mem_port.sv
`default_nettype none
// ============================================================================
// data_mem_port: data-memory responder with a fixed access latency, a sticky
// error flag and saturating load/store counters.  Revision: 1.0
// ============================================================================
module data_mem_port #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]        CNT_INIT = 4'(LATENCY - 1);
  localparam logic [15:0]       CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [15:0]         rd_count_q, rd_count_d;
  logic [15:0]         wr_count_q, wr_count_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                req;
  logic                acc_in_range;
  logic                commit;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_wdata;
  logic                c_wr;
  logic                c_in_range;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_we;
  logic                stall_raw;
  logic                rvalid_raw;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_wr_d      = is_wr_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    commit       = 1'b0;
    c_addr       = addr_q;
    c_wdata      = wdata_q;
    c_wr         = is_wr_q;
    stall_raw    = 1'b0;
    rvalid_raw   = 1'b0;
    req          = memRead | memWrite;
    acc_in_range = ({1'b0, addr} < DEPTH_L);

    case (state_q)
      IDLE: begin
        stall_raw = req;
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          is_wr_d = memWrite;
          cnt_d   = CNT_INIT;
          if ((memRead & memWrite) | ~acc_in_range) begin
            err_d = 1'b1;
          end
          // Single-cycle latency commits straight from the request inputs.
          if (LATENCY == 1) begin
            state_d = DONE;
            commit  = 1'b1;
            c_addr  = addr;
            c_wdata = wdata;
            c_wr    = memWrite;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall_raw = 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        rvalid_raw = ~is_wr_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    c_in_range = ({1'b0, c_addr} < DEPTH_L);
    mem_rdata  = mem_q[c_addr[IDX_W-1:0]];

    if (commit) begin
      if (c_wr) begin
        if (wr_count_q != CNT_MAX) wr_count_d = wr_count_q + 16'd1;
      end else begin
        if (rd_count_q != CNT_MAX) rd_count_d = rd_count_q + 16'd1;
        rdata_d = c_in_range ? mem_rdata : '0;
      end
    end

    mem_we = commit & c_wr & c_in_range & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[c_addr[IDX_W-1:0]] <= c_wdata;
    end
  end

  assign stall    = stall_raw & ~reset;
  assign rvalid   = rvalid_raw & ~reset;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_port.sv
`default_nettype none
// ============================================================================
// tb_data_mem_port: scoreboard bench over four parameterisations of the port.
// Revision: 1.0
// ============================================================================
module tb_data_mem_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  int          sel;

  logic [3:0]        stall_v;
  logic [3:0]        rvalid_v;
  logic [3:0]        err_v;
  logic [3:0][7:0]   rdata_v;
  logic [3:0][15:0]  rdc_v;
  logic [3:0][15:0]  wrc_v;

  // Instance 0: LATENCY 2, 1: LATENCY 1, 2: LATENCY 2 / DEPTH 16, 3: LATENCY 4
  data_mem_port #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .LATENCY(2)) u_d0 (
    .clk(clk), .reset(reset),
    .memRead(mem_read && (sel == 0)), .memWrite(mem_write && (sel == 0)),
    .addr(addr), .wdata(wdata),
    .stall(stall_v[0]), .rvalid(rvalid_v[0]), .rdata(rdata_v[0]),
    .err(err_v[0]), .rd_count(rdc_v[0]), .wr_count(wrc_v[0])
  );
  data_mem_port #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .LATENCY(1)) u_d1 (
    .clk(clk), .reset(reset),
    .memRead(mem_read && (sel == 1)), .memWrite(mem_write && (sel == 1)),
    .addr(addr), .wdata(wdata),
    .stall(stall_v[1]), .rvalid(rvalid_v[1]), .rdata(rdata_v[1]),
    .err(err_v[1]), .rd_count(rdc_v[1]), .wr_count(wrc_v[1])
  );
  data_mem_port #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .LATENCY(2)) u_d2 (
    .clk(clk), .reset(reset),
    .memRead(mem_read && (sel == 2)), .memWrite(mem_write && (sel == 2)),
    .addr(addr), .wdata(wdata),
    .stall(stall_v[2]), .rvalid(rvalid_v[2]), .rdata(rdata_v[2]),
    .err(err_v[2]), .rd_count(rdc_v[2]), .wr_count(wrc_v[2])
  );
  data_mem_port #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .LATENCY(4)) u_d3 (
    .clk(clk), .reset(reset),
    .memRead(mem_read && (sel == 3)), .memWrite(mem_write && (sel == 3)),
    .addr(addr), .wdata(wdata),
    .stall(stall_v[3]), .rvalid(rvalid_v[3]), .rdata(rdata_v[3]),
    .err(err_v[3]), .rd_count(rdc_v[3]), .wr_count(wrc_v[3])
  );

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  model   [4][256];
  logic [15:0] exp_rd  [4];
  logic [15:0] exp_wr  [4];
  logic        exp_err [4];
  logic [7:0]  sb [$];

  function automatic bit in_range(input int d, input logic [7:0] a);
    return (d == 2) ? (a < 8'd16) : 1'b1;
  endfunction

  task automatic clear_expect();
    for (int d = 0; d < 4; d++) begin
      exp_rd[d]  = 16'd0;
      exp_wr[d]  = 16'd0;
      exp_err[d] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_expect();
  endtask

  // One instruction: requests held through the stall cycles and the DONE cycle.
  task automatic run_op(input int d, input int lat, input bit rd, input bit wr,
                        input logic [7:0] a, input logic [7:0] wd);
    logic       exp_rv;
    logic [7:0] got;
    exp_rv = rd && !wr;
    if (rd || wr) exp_err[d] = exp_err[d] | (rd && wr) | !in_range(d, a);
    if (wr) begin
      if (in_range(d, a)) model[d][a] = wd;
      if (exp_wr[d] != 16'hFFFF) exp_wr[d] = exp_wr[d] + 16'd1;
    end else if (rd) begin
      sb.push_back(in_range(d, a) ? model[d][a] : 8'h00);
      if (exp_rd[d] != 16'hFFFF) exp_rd[d] = exp_rd[d] + 16'd1;
    end

    @(negedge clk);
    sel = d; mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    for (int c = 0; c < lat; c++) begin
      #1;
      checks++;
      if ({stall_v[d], rvalid_v[d]} !== 2'b10)
        $display("FAIL stall_phase d%0d cyc%0d: got stall/rvalid=%b expected 10",
                 d, c, {stall_v[d], rvalid_v[d]});
      if ({stall_v[d], rvalid_v[d]} !== 2'b10) errors++;
      @(negedge clk);
    end
    #1;
    checks++;
    if ({stall_v[d], rvalid_v[d]} !== {1'b0, exp_rv}) begin
      errors++;
      $display("FAIL done_phase d%0d: got stall/rvalid=%b expected %b",
               d, {stall_v[d], rvalid_v[d]}, {1'b0, exp_rv});
    end
    if (rvalid_v[d] === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected d%0d: got rdata=%h expected no load", d, rdata_v[d]);
      end else begin
        got = sb.pop_front();
        if (rdata_v[d] !== got) begin
          errors++;
          $display("FAIL rdata d%0d addr %h: got %h expected %h", d, a, rdata_v[d], got);
        end
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    checks++;
    if ({rdc_v[d], wrc_v[d], err_v[d]} !== {exp_rd[d], exp_wr[d], exp_err[d]}) begin
      errors++;
      $display("FAIL status d%0d: got rd=%h wr=%h err=%b expected rd=%h wr=%h err=%b",
               d, rdc_v[d], wrc_v[d], err_v[d], exp_rd[d], exp_wr[d], exp_err[d]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({stall_v[d], rvalid_v[d], err_v[d], rdata_v[d], rdc_v[d], wrc_v[d]} !== '0) begin
        errors++;
        $display("FAIL reset_state d%0d: got stall=%b rvalid=%b err=%b rdata=%h rd=%h wr=%h expected all 0",
                 d, stall_v[d], rvalid_v[d], err_v[d], rdata_v[d], rdc_v[d], wrc_v[d]);
      end
    end
  endtask

  task automatic test_store_load();
    run_op(0, 2, 1'b0, 1'b1, 8'h10, 8'hA5);
    run_op(0, 2, 1'b1, 1'b0, 8'h10, 8'h00);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run_op(1, 1, 1'b0, 1'b1, 8'(i), 8'(8'h5A + 37 * i));
      run_op(1, 1, 1'b1, 1'b0, 8'(i), 8'h00);
    end
    for (int i = 3; i >= 0; i--) run_op(1, 1, 1'b1, 1'b0, 8'(i), 8'h00);
  endtask

  task automatic test_both_high();
    run_op(0, 2, 1'b1, 1'b1, 8'h05, 8'h3C);
    run_op(0, 2, 1'b1, 1'b0, 8'h05, 8'h00);
    run_op(0, 2, 1'b0, 1'b1, 8'h06, 8'h42);
  endtask

  task automatic test_out_of_range();
    run_op(2, 2, 1'b0, 1'b1, 8'h0F, 8'hC3);
    run_op(2, 2, 1'b0, 1'b1, 8'h20, 8'hFF);
    run_op(2, 2, 1'b1, 1'b0, 8'h20, 8'h00);
    run_op(2, 2, 1'b1, 1'b0, 8'h0F, 8'h00);
  endtask

  task automatic test_reset_in_wait();
    run_op(3, 4, 1'b0, 1'b1, 8'h02, 8'h11);
    @(negedge clk);
    sel = 3; mem_write = 1'b1; addr = 8'h02; wdata = 8'h77;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mem_write = 1'b0;
    clear_expect();
    #1;
    checks++;
    if ({stall_v[3], rvalid_v[3], rdc_v[3], wrc_v[3], err_v[3]} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: got stall=%b rvalid=%b rd=%h wr=%h err=%b expected all 0",
               stall_v[3], rvalid_v[3], rdc_v[3], wrc_v[3], err_v[3]);
    end
    run_op(3, 4, 1'b1, 1'b0, 8'h02, 8'h00);
  endtask

  task automatic test_saturate();
    run_op(0, 2, 1'b0, 1'b1, 8'h30, 8'h01);
    run_op(0, 2, 1'b0, 1'b1, 8'h31, 8'h02);
    @(negedge clk);
    force u_d0.wr_count_q = 16'hFFFE;
    @(negedge clk);
    release u_d0.wr_count_q;
    exp_wr[0] = 16'hFFFE;
    @(negedge clk);
    #1;
    checks++;
    if (wrc_v[0] !== 16'hFFFE) begin
      errors++;
      $display("FAIL preload: got wr_count=%h expected fffe", wrc_v[0]);
    end
    for (int i = 0; i < 3; i++) run_op(0, 2, 1'b0, 1'b1, 8'(8'h40 + i), 8'(i));
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = 8'h00; wdata = 8'h00; sel = 0;
    clear_expect();
    for (int d = 0; d < 4; d++)
      for (int a = 0; a < 256; a++) model[d][a] = 8'h00;
    repeat (2) @(negedge clk);

    test_reset();
    test_store_load();
    test_back_to_back();
    test_both_high();
    test_out_of_range();
    test_reset_in_wait();
    test_saturate();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending loads expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
